// File: rtl/alu_pkg.sv
// Shared ALU select codes, datapath widths and the arbiter FSM state type.
// Contents:
//   DATA_W, SEL_W         ALU operand/result width and select width
//   ALU_AND..ALU_NOR      ALU select encodings
//   arb_state_t           IDLE -> EXEC -> RESP arbiter sequence
//   is_zero()             zero detect used for the response flag
package alu_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned SEL_W  = 4;

  localparam logic [SEL_W-1:0] ALU_AND = 4'b0000;
  localparam logic [SEL_W-1:0] ALU_OR  = 4'b0001;
  localparam logic [SEL_W-1:0] ALU_ADD = 4'b0010;
  localparam logic [SEL_W-1:0] ALU_SUB = 4'b0110;
  localparam logic [SEL_W-1:0] ALU_SLT = 4'b0111;
  localparam logic [SEL_W-1:0] ALU_NOR = 4'b1100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  function automatic logic is_zero(input logic [DATA_W-1:0] v);
    return (v == '0);
  endfunction

endpackage

// File: rtl/alu_arb_pick.sv
// Combinational winner select for the ALU arbiter.
// Build option ARB_ROUND_ROBIN_EN:
//   defined   - first valid requester at or after rr_ptr_i, wrapping
//   undefined - fixed priority, lowest index wins (no rr_ptr_i port)
// Ports:
//   req_valid_i  per-requester valid
//   rr_ptr_i     round-robin start index (round-robin build only)
//   grant_o      one-hot grant, zero when nothing is valid
//   idx_o        encoded winner index (0 when nothing is valid)
//   any_valid_o  at least one requester is valid
module alu_arb_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req_valid_i,
`ifdef ARB_ROUND_ROBIN_EN
  input  logic [ID_W-1:0]    rr_ptr_i,
`endif
  output logic [NUM_REQ-1:0] grant_o,
  output logic [ID_W-1:0]    idx_o,
  output logic               any_valid_o
);

  logic found;

  // Scan requesters in priority order; the first valid one wins.
  always_comb begin
    found       = 1'b0;
    idx_o       = '0;
    any_valid_o = |req_valid_i;
`ifdef ARB_ROUND_ROBIN_EN
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      int unsigned cand;
      cand = 32'(rr_ptr_i) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!found && req_valid_i[ID_W'(cand)]) begin
        found = 1'b1;
        idx_o = ID_W'(cand);
      end
    end
`else
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!found && req_valid_i[ID_W'(k)]) begin
        found = 1'b1;
        idx_o = ID_W'(k);
      end
    end
`endif
    grant_o = found ? (NUM_REQ'(1) << idx_o) : '0;
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational 32-bit ALU between NUM_REQ requesters.
// One operation in flight: IDLE (grant + latch operands) -> EXEC (ALU driven,
// result captured) -> RESP (response held until accepted).
// Build option ARB_ROUND_ROBIN_EN selects round-robin arbitration; otherwise
// fixed priority with the lowest index winning.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   req_valid/req_ready        per-requester handshake (ready is one-hot or 0)
//   req_op1/req_op2/req_sel    packed per-requester operands and select
//   alu_op1/alu_op2/alu_sel    registered drive to the ALU
//   alu_c                      ALU result (combinational)
//   rsp_valid/rsp_ready        response handshake
//   rsp_id/rsp_c/rsp_z         winner index, captured result, zero flag
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_op1,
  input  logic [NUM_REQ*DATA_W-1:0] req_op2,
  input  logic [NUM_REQ*SEL_W-1:0]  req_sel,
  output logic [DATA_W-1:0]         alu_op1,
  output logic [DATA_W-1:0]         alu_op2,
  output logic [SEL_W-1:0]          alu_sel,
  input  logic [DATA_W-1:0]         alu_c,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic [DATA_W-1:0]         rsp_c,
  output logic                      rsp_z
);

  arb_state_t          state_q, state_d;
  logic [DATA_W-1:0]   alu_op1_q, alu_op1_d;
  logic [DATA_W-1:0]   alu_op2_q, alu_op2_d;
  logic [SEL_W-1:0]    alu_sel_q, alu_sel_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]     rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0]   rsp_c_q, rsp_c_d;
  logic                rsp_z_q, rsp_z_d;
`ifdef ARB_ROUND_ROBIN_EN
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
`endif

  logic [NUM_REQ-1:0]  grant_c;
  logic [ID_W-1:0]     win_idx_c;
  logic                any_valid_c;

  alu_arb_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req_valid_i (req_valid),
`ifdef ARB_ROUND_ROBIN_EN
    .rr_ptr_i    (rr_ptr_q),
`endif
    .grant_o     (grant_c),
    .idx_o       (win_idx_c),
    .any_valid_o (any_valid_c)
  );

  // Next-state and handshake logic; registers hold unless a state updates them.
  always_comb begin
    state_d     = state_q;
    alu_op1_d   = alu_op1_q;
    alu_op2_d   = alu_op2_q;
    alu_sel_d   = alu_sel_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_c_d     = rsp_c_q;
    rsp_z_d     = rsp_z_q;
`ifdef ARB_ROUND_ROBIN_EN
    rr_ptr_d    = rr_ptr_q;
`endif
    req_ready   = '0;

    unique case (state_q)
      IDLE: begin
        if (any_valid_c) begin
          req_ready = grant_c;
          alu_op1_d = req_op1[DATA_W*win_idx_c +: DATA_W];
          alu_op2_d = req_op2[DATA_W*win_idx_c +: DATA_W];
          alu_sel_d = req_sel[SEL_W*win_idx_c +: SEL_W];
          rsp_id_d  = win_idx_c;
`ifdef ARB_ROUND_ROBIN_EN
          // Pointer moves past the winner only when a grant is taken.
          rr_ptr_d  = (win_idx_c == ID_W'(NUM_REQ - 1)) ? '0 : win_idx_c + ID_W'(1);
`endif
          state_d   = EXEC;
        end
      end
      EXEC: begin
        rsp_c_d     = alu_c;
        rsp_z_d     = is_zero(alu_c);
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and data registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      alu_op1_q   <= '0;
      alu_op2_q   <= '0;
      alu_sel_q   <= ALU_AND;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_c_q     <= '0;
      rsp_z_q     <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      rr_ptr_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      alu_op1_q   <= alu_op1_d;
      alu_op2_q   <= alu_op2_d;
      alu_sel_q   <= alu_sel_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_c_q     <= rsp_c_d;
      rsp_z_q     <= rsp_z_d;
`ifdef ARB_ROUND_ROBIN_EN
      rr_ptr_q    <= rr_ptr_d;
`endif
    end
  end

  assign alu_op1   = alu_op1_q;
  assign alu_op2   = alu_op2_q;
  assign alu_sel   = alu_sel_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_c     = rsp_c_q;
  assign rsp_z     = rsp_z_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: directed operations push hand-computed
// responses into a queue; a negedge monitor pops and compares on every
// accepted response. A behavioural ALU sits on the alu_* port.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned ID_W    = 2;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [31:0]     c;
    logic            z;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ*32-1:0] req_op1;
  logic [NUM_REQ*32-1:0] req_op2;
  logic [NUM_REQ*4-1:0] req_sel;
  logic [31:0]          alu_op1;
  logic [31:0]          alu_op2;
  logic [3:0]           alu_sel;
  logic [31:0]          alu_c;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [ID_W-1:0]      rsp_id;
  logic [31:0]          rsp_c;
  logic                 rsp_z;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op1   (req_op1),
    .req_op2   (req_op2),
    .req_sel   (req_sel),
    .alu_op1   (alu_op1),
    .alu_op2   (alu_op2),
    .alu_sel   (alu_sel),
    .alu_c     (alu_c),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_c     (rsp_c),
    .rsp_z     (rsp_z)
  );

  // Behavioural ALU; unknown selects give zero.
  always_comb begin
    case (alu_sel)
      ALU_AND: alu_c = alu_op1 & alu_op2;
      ALU_OR:  alu_c = alu_op1 | alu_op2;
      ALU_ADD: alu_c = alu_op1 + alu_op2;
      ALU_SUB: alu_c = alu_op1 - alu_op2;
      ALU_SLT: alu_c = ($signed(alu_op1) < $signed(alu_op2)) ? 32'd1 : 32'd0;
      ALU_NOR: alu_c = ~(alu_op1 | alu_op2);
      default: alu_c = 32'd0;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Response monitor: compare every accepted response against the queue head.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_rsp: got id %0d c 0x%08h, no response expected", rsp_id, rsp_c);
      end else begin
        e = sb.pop_front();
        chk("rsp_id", 32'(rsp_id), 32'(e.id));
        chk("rsp_c", rsp_c, e.c);
        chk("rsp_z", 32'(rsp_z), 32'(e.z));
      end
    end
  end

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b, input logic [3:0] s);
    req_op1[32*i +: 32] = a;
    req_op2[32*i +: 32] = b;
    req_sel[4*i +: 4]   = s;
  endtask

  // Wait (bounded) for requester i to be granted, then drop its valid after the accept edge.
  task automatic wait_grant(input int i);
    int cyc;
    logic [NUM_REQ-1:0] oh;
    oh  = NUM_REQ'(1) << i;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!req_ready[i] && cyc < 50);
    chk("grant", 32'(req_ready), 32'(oh));
    @(posedge clk);
    #1 req_valid[i] = 1'b0;
  endtask

  task automatic issue(input int i, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] s, input logic [31:0] ec, input logic ez);
    exp_t e;
    set_op(i, a, b, s);
    e.id = ID_W'(i);
    e.c  = ec;
    e.z  = ez;
    sb.push_back(e);
    req_valid[i] = 1'b1;
    wait_grant(i);
  endtask

  task automatic drain();
    int cyc;
    cyc = 0;
    while ((sb.size() != 0 || rsp_valid) && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("drain", 32'(sb.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin : stim
    exp_t e;
    int   exp_ids[5];
    logic [31:0] res[4];
    int   cyc;

    rst_n     = 1'b0;
    req_valid = '0;
    req_op1   = '0;
    req_op2   = '0;
    req_sel   = '0;
    rsp_ready = 1'b1;

    // Reset values
    #7;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_c", rsp_c, 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_rsp_z", 32'(rsp_z), 32'd0);
    chk("rst_alu_op1", alu_op1, 32'd0);
    chk("rst_alu_sel", 32'(alu_sel), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // 1. ADD 5+7 from req 0, with exact latency checks
    issue(0, 32'd5, 32'd7, ALU_ADD, 32'd12, 1'b0);
    @(negedge clk);
    chk("t1_ready_one_cycle", 32'(req_ready), 32'd0);
    chk("t1_exec_no_valid", 32'(rsp_valid), 32'd0);
    chk("t1_alu_op1", alu_op1, 32'd5);
    @(negedge clk);
    chk("t1_rsp_valid_lat2", 32'(rsp_valid), 32'd1);
    drain();

    // 2. Ops from req 2
    issue(2, 32'd9, 32'd9, ALU_SUB, 32'd0, 1'b1);
    drain();
    issue(2, 32'd3, 32'd4, ALU_SLT, 32'd1, 1'b0);
    drain();
    issue(2, 32'd0, 32'd0, ALU_NOR, 32'hFFFF_FFFF, 1'b0);
    drain();

    // 3. All four valid continuously
    do_reset();
    set_op(0, 32'd1, 32'd2, ALU_ADD);          res[0] = 32'd3;
    set_op(1, 32'd10, 32'd4, ALU_SUB);         res[1] = 32'd6;
    set_op(2, 32'h0000_00F0, 32'h0000_003C, ALU_AND); res[2] = 32'h0000_0030;
    set_op(3, 32'h0000_0100, 32'h0000_0001, ALU_OR);  res[3] = 32'h0000_0101;
`ifdef ARB_ROUND_ROBIN_EN
    exp_ids = '{0, 1, 2, 3, 0};
`else
    exp_ids = '{0, 0, 0, 0, 0};
`endif
    for (int g = 0; g < 5; g++) begin
      e.id = ID_W'(exp_ids[g]);
      e.c  = res[exp_ids[g]];
      e.z  = 1'b0;
      sb.push_back(e);
    end
    req_valid = '1;
    for (int g = 0; g < 5; g++) begin
      cyc = 0;
      do begin
        @(negedge clk);
        cyc++;
      end while (req_ready == '0 && cyc < 50);
      chk("arb_grant_order", 32'(req_ready), 32'(NUM_REQ'(1) << exp_ids[g]));
      @(posedge clk);
    end
    #1 req_valid = '0;
    drain();

    // 4. Response backpressure with another request waiting
    rsp_ready = 1'b0;
    issue(3, 32'h10, 32'h20, ALU_ADD, 32'h30, 1'b0);
    set_op(1, 32'hFF, 32'h0F, ALU_AND);
    e.id = ID_W'(1); e.c = 32'h0F; e.z = 1'b0;
    sb.push_back(e);
    req_valid[1] = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!rsp_valid && cyc < 50);
    for (int k = 0; k < 5; k++) begin
      chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_rsp_c", rsp_c, 32'h30);
      chk("bp_rsp_id", 32'(rsp_id), 32'd3);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    wait_grant(1);
    drain();

    // 5. Reset while in EXEC
    set_op(3, 32'd40, 32'd2, ALU_ADD);
    req_valid[3] = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!req_ready[3] && cyc < 50);
    chk("t5_grant", 32'(req_ready), 32'h8);
    @(posedge clk);
    #2 rst_n = 1'b0;
    req_valid = '0;
    #1;
    chk("t5_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("t5_alu_op1", alu_op1, 32'd0);
    chk("t5_alu_op2", alu_op2, 32'd0);
    chk("t5_rsp_id", 32'(rsp_id), 32'd0);
    chk("t5_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("t5_no_rsp", 32'(rsp_valid), 32'd0);
    end

    // 6. Undefined select from req 1
    issue(1, 32'd5, 32'd6, 4'b1010, 32'd0, 1'b1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
